// File: rtl/fifo_deq_unpacker.sv
// fifo_deq_unpacker
// Pops one wide word from a Bluespec-style FIFO (D_OUT/EMPTY_N/DEQ) and replays
// it as `beats` narrow beats on a valid/ready stream, least-significant slice
// first. The next word is popped in the same cycle the last beat fires, so
// back-to-back words stream at one beat per cycle with no bubble.
//
// Handshake: a beat transfers on a rising CLK edge where OUT_VALID && OUT_READY.
// Once OUT_VALID is raised it stays high, with OUT_DATA/OUT_LAST frozen, until
// that beat transfers; only CLR or RST_N may withdraw it.
//
// The FSM has two states, so BUSY is a direct copy of the state register and
// serves as the state debug output.
module fifo_deq_unpacker #(
    parameter int width = 32,
    parameter int beats = 4
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   CLR,
    input  logic [width-1:0]       FIFO_D_OUT,
    input  logic                   FIFO_EMPTY_N,
    output logic                   FIFO_DEQ,
    output logic [width/beats-1:0] OUT_DATA,
    output logic                   OUT_VALID,
    input  logic                   OUT_READY,
    output logic                   OUT_LAST,
    output logic                   BUSY
);

    localparam int BW = width / beats;
    localparam int CW = (beats > 1) ? $clog2(beats) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(beats - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_SEND = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [width-1:0] shreg_q, shreg_d;

    logic send;
    logic fire;
    logic take;

    assign send      = (state_q == S_SEND);
    assign OUT_VALID = send;
    assign BUSY      = send;
    assign OUT_DATA  = shreg_q[BW-1:0];
    assign OUT_LAST  = send && (cnt_q == LAST_CNT);

    assign fire = send && OUT_READY;
    // A new word may be taken when nothing is held, or when the held word's
    // final beat leaves this very cycle.
    assign take = !send || (fire && OUT_LAST);

    // Reset gates the pop combinationally so the FIFO is never drained while
    // this block is being held in reset.
    assign FIFO_DEQ = RST_N && !CLR && FIFO_EMPTY_N && take;

    // Next-state: clear first, then load on pop, then shift on a non-final beat.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        if (CLR) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else if (FIFO_DEQ) begin
            state_d = S_SEND;
            cnt_d   = '0;
            shreg_d = FIFO_D_OUT;
        end else if (fire && !OUT_LAST) begin
            cnt_d   = cnt_q + CW'(1);
            shreg_d = shreg_q >> BW;
        end else if (fire) begin
            state_d = S_IDLE;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
        end
    end

`ifndef SYNTHESIS
    // A pop must never be issued against an empty FIFO.
    a_no_deq_when_empty : assert property (
        @(posedge CLK) disable iff (!RST_N) FIFO_DEQ |-> FIFO_EMPTY_N
    );
`endif

endmodule

// File: tb/tb_fifo_deq_unpacker.sv
// Bench for fifo_deq_unpacker: a 32-bit/4-beat instance and an 8-bit/1-beat
// instance, each fed from a queue acting as the upstream FIFO. The reference
// model expands each popped word into its list of expected beats; a beat is
// valid while that list is non-empty and it is the last beat when one remains.
module tb_fifo_deq_unpacker;

    localparam int WA  = 32;
    localparam int NA  = 4;
    localparam int BWA = WA / NA;
    localparam int WB  = 8;
    localparam int NB  = 1;
    localparam int BWB = WB / NB;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- DUT signals ----------------
    logic           clr_a, empty_n_a, deq_a, valid_a, ready_a, last_a, busy_a;
    logic [WA-1:0]  d_a;
    logic [BWA-1:0] data_a;
    logic           clr_b, empty_n_b, deq_b, valid_b, ready_b, last_b, busy_b;
    logic [WB-1:0]  d_b;
    logic [BWB-1:0] data_b;

    fifo_deq_unpacker #(.width(WA), .beats(NA)) u_dut_a (
        .CLK(clk), .RST_N(rst_n), .CLR(clr_a),
        .FIFO_D_OUT(d_a), .FIFO_EMPTY_N(empty_n_a), .FIFO_DEQ(deq_a),
        .OUT_DATA(data_a), .OUT_VALID(valid_a), .OUT_READY(ready_a),
        .OUT_LAST(last_a), .BUSY(busy_a)
    );

    fifo_deq_unpacker #(.width(WB), .beats(NB)) u_dut_b (
        .CLK(clk), .RST_N(rst_n), .CLR(clr_b),
        .FIFO_D_OUT(d_b), .FIFO_EMPTY_N(empty_n_b), .FIFO_DEQ(deq_b),
        .OUT_DATA(data_b), .OUT_VALID(valid_b), .OUT_READY(ready_b),
        .OUT_LAST(last_b), .BUSY(busy_b)
    );

    // ---------------- upstream FIFOs and scoreboard ----------------
    logic [WA-1:0]  fifo_a_q[$];
    logic [WB-1:0]  fifo_b_q[$];
    logic [BWA-1:0] exp_q[$];
    logic [BWB-1:0] exp_b_q[$];
    logic           pop_a, pop_b;
    int             n_checks, n_errors;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void drive_fifos();
        empty_n_a = (fifo_a_q.size() != 0);
        d_a       = (fifo_a_q.size() != 0) ? fifo_a_q[0] : '0;
        empty_n_b = (fifo_b_q.size() != 0);
        d_b       = (fifo_b_q.size() != 0) ? fifo_b_q[0] : '0;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_a(input logic [WA-1:0] w);
        fifo_a_q.push_back(w);
        drive_fifos();
    endtask

    task automatic push_b(input logic [WB-1:0] w);
        fifo_b_q.push_back(w);
        drive_fifos();
    endtask

    // Upstream FIFO pops on the edge after the model decided a pop happens.
    always @(posedge clk) begin
        #1;
        if (pop_a) void'(fifo_a_q.pop_front());
        if (pop_b) void'(fifo_b_q.pop_front());
        pop_a = 1'b0;
        pop_b = 1'b0;
        drive_fifos();
    end

    // Reference model + checks for the 4-beat instance, sampled mid-cycle.
    always @(negedge clk) begin : mon_a
        logic          ev, el, fr, ed;
        logic [WA-1:0] w;
        if (!rst_n) begin
            check_eq("a_rst_valid", valid_a, 0);
            check_eq("a_rst_deq", deq_a, 0);
            exp_q.delete();
            pop_a = 1'b0;
        end else begin
            ev = (exp_q.size() != 0);
            el = (exp_q.size() == 1);
            fr = ev && ready_a;
            ed = !clr_a && (fifo_a_q.size() != 0) && (!ev || (fr && el));
            check_eq("a_valid", valid_a, ev);
            check_eq("a_busy", busy_a, ev);
            check_eq("a_last", last_a, ev && el);
            check_eq("a_deq", deq_a, ed);
            if (ev) check_eq("a_data", data_a, exp_q[0]);
            if (clr_a) begin
                exp_q.delete();
            end else begin
                if (fr) void'(exp_q.pop_front());
                if (ed) begin
                    w = fifo_a_q[0];
                    for (int b = 0; b < NA; b++) exp_q.push_back(w[b*BWA +: BWA]);
                end
            end
            pop_a = ed;
        end
    end

    // Reference model + checks for the single-beat instance.
    always @(negedge clk) begin : mon_b
        logic ev, fr, ed;
        if (!rst_n) begin
            check_eq("b_rst_valid", valid_b, 0);
            check_eq("b_rst_deq", deq_b, 0);
            exp_b_q.delete();
            pop_b = 1'b0;
        end else begin
            ev = (exp_b_q.size() != 0);
            fr = ev && ready_b;
            ed = !clr_b && (fifo_b_q.size() != 0) && (!ev || fr);
            check_eq("b_valid", valid_b, ev);
            check_eq("b_last", last_b, ev);
            check_eq("b_deq", deq_b, ed);
            if (ev) check_eq("b_data", data_b, exp_b_q[0]);
            if (clr_b) begin
                exp_b_q.delete();
            end else begin
                if (fr) void'(exp_b_q.pop_front());
                if (ed) exp_b_q.push_back(fifo_b_q[0]);
            end
            pop_b = ed;
        end
    end

    // ---------------- stimulus ----------------
    initial begin : main
        logic [31:0] w1, w2;
        logic [7:0]  v;
        n_checks = 0;
        n_errors = 0;
        pop_a = 1'b0;
        pop_b = 1'b0;
        rst_n = 1'b0;
        clr_a = 1'b0;
        clr_b = 1'b0;
        ready_a = 1'b0;
        ready_b = 1'b0;
        drive_fifos();

        // Reset state
        #2;
        check_eq("rst_data", data_a, 0);
        check_eq("rst_last", last_a, 0);
        check_eq("rst_busy", busy_a, 0);
        check_eq("rst_busy_b", busy_b, 0);
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // 1: single word, four beats LSB first
        w1 = 32'hDDCCBBAA;
        push_a(w1);
        ready_a = 1'b1;
        @(negedge clk);
        check_eq("t1_deq", deq_a, 1);
        check_eq("t1_valid0", valid_a, 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            @(negedge clk);
            check_eq("t1_data", data_a, w1[8*k +: 8]);
            check_eq("t1_last", last_a, (k == 3));
            check_eq("t1_nodeq", deq_a, 0);
        end
        tick();
        @(negedge clk);
        check_eq("t1_idle", busy_a, 0);

        // 2: backpressure on beat BB
        push_a(w1);
        tick();
        tick();
        ready_a = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_eq("t2_hold_data", data_a, 8'hBB);
            check_eq("t2_hold_valid", valid_a, 1);
            check_eq("t2_hold_nodeq", deq_a, 0);
            tick();
        end
        ready_a = 1'b1;
        @(negedge clk);
        check_eq("t2_fire_bb", data_a, 8'hBB);
        tick();
        @(negedge clk);
        check_eq("t2_next_cc", data_a, 8'hCC);
        repeat (3) tick();

        // 3: back-to-back words, no bubble
        w1 = 32'h44332211;
        w2 = 32'h88776655;
        push_a(w1);
        push_a(w2);
        for (int k = 0; k < 8; k++) begin
            tick();
            @(negedge clk);
            check_eq("t3_valid", valid_a, 1);
            check_eq("t3_data", data_a, (k < 4) ? w1[8*k +: 8] : w2[8*(k-4) +: 8]);
            check_eq("t3_last", last_a, (k == 3) || (k == 7));
            check_eq("t3_deq", deq_a, (k == 3));
        end
        tick();
        @(negedge clk);
        check_eq("t3_idle", valid_a, 0);

        // 4: CLR while BB is shown drops the word; next word restarts at beat0
        w1 = 32'hDDCCBBAA;
        w2 = 32'h87654321;
        push_a(w1);
        push_a(w2);
        tick();
        tick();
        clr_a = 1'b1;
        @(negedge clk);
        check_eq("t4_clr_nodeq", deq_a, 0);
        tick();
        clr_a = 1'b0;
        @(negedge clk);
        check_eq("t4_after_clr_valid", valid_a, 0);
        check_eq("t4_after_clr_deq", deq_a, 1);
        for (int k = 0; k < 4; k++) begin
            tick();
            @(negedge clk);
            check_eq("t4_data", data_a, w2[8*k +: 8]);
            check_eq("t4_last", last_a, (k == 3));
        end
        tick();

        // 5: asynchronous reset mid-SEND, while a pop would otherwise happen
        push_a(32'hDDCCBBAA);
        push_a(32'h12345678);
        repeat (4) tick();
        #1;
        check_eq("t5_pre_deq", deq_a, 1);
        check_eq("t5_pre_last", last_a, 1);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("t5_async_valid", valid_a, 0);
        check_eq("t5_async_busy", busy_a, 0);
        check_eq("t5_async_deq", deq_a, 0);
        check_eq("t5_async_data", data_a, 0);
        fifo_a_q.delete();
        drive_fifos();
        repeat (2) tick();
        #2;
        rst_n = 1'b1;
        repeat (2) tick();
        check_eq("t5_post_valid", valid_a, 0);
        check_eq("t5_post_busy", busy_a, 0);
        check_eq("t5_post_deq", deq_a, 0);

        // 6: single-beat instance sustains one word per cycle
        ready_b = 1'b1;
        push_b(8'h5A);
        push_b(8'hA5);
        push_b(8'h3C);
        @(negedge clk);
        check_eq("t6_deq0", deq_b, 1);
        for (int k = 0; k < 3; k++) begin
            tick();
            @(negedge clk);
            check_eq("t6_valid", valid_b, 1);
            check_eq("t6_last", last_b, 1);
            check_eq("t6_data", data_b, (k == 0) ? 8'h5A : (k == 1) ? 8'hA5 : 8'h3C);
            check_eq("t6_deq", deq_b, (k < 2));
        end
        tick();
        @(negedge clk);
        check_eq("t6_idle", valid_b, 0);

        // Randomized traffic, backpressure and occasional clears
        for (int i = 0; i < 600; i++) begin
            tick();
            ready_a = ($urandom_range(0, 3) != 0);
            ready_b = ($urandom_range(0, 2) != 0);
            clr_a   = ($urandom_range(0, 39) == 0);
            clr_b   = ($urandom_range(0, 49) == 0);
            if (fifo_a_q.size() < 2 && $urandom_range(0, 2) != 0) push_a($urandom);
            if (fifo_b_q.size() < 2 && $urandom_range(0, 1) != 0) begin
                v = 8'($urandom);
                push_b(v);
            end
        end

        // Drain
        tick();
        ready_a = 1'b1;
        ready_b = 1'b1;
        clr_a   = 1'b0;
        clr_b   = 1'b0;
        repeat (20) tick();
        @(negedge clk);
        check_eq("drain_fifo_a", fifo_a_q.size(), 0);
        check_eq("drain_exp_a", exp_q.size(), 0);
        check_eq("drain_fifo_b", fifo_b_q.size(), 0);
        check_eq("drain_exp_b", exp_b_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
